// File: rtl/eq3_test_pkg.sv
// Shared types and constants for the 3-input gate self-test sequencer.
package eq3_test_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned VEC_W   = 3;
    localparam int unsigned ERR_W   = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [NUM_VEC-1:0] GOLDEN_EQ3 = 8'h81;
    localparam logic [VEC_W-1:0]   LAST_VEC   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // 1 when the observed gate output agrees with the golden bit for this vector
    function automatic logic vec_match(input logic [NUM_VEC-1:0] golden,
                                       input logic [VEC_W-1:0]   idx,
                                       input logic               observed);
        return observed == golden[idx];
    endfunction

endpackage

// File: rtl/eq3_sweep_ctrl_settle_timer.sv
// Per-vector settle counter: counts while enabled, flags the last settle cycle.
module settle_timer
    import eq3_test_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/eq3_sweep_ctrl.sv
// Self-test sequencer: sweeps all 8 input vectors through a 3-input gate,
// samples its output after a settle time and accumulates pass/fail results.
module eq3_sweep_ctrl
    import eq3_test_pkg::*;
#(
    parameter int unsigned          SETTLE = 2,
    parameter logic [NUM_VEC-1:0]   GOLDEN = GOLDEN_EQ3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               dut_out,
    output logic               drv_a,
    output logic               drv_b,
    output logic               drv_c,
    output logic [VEC_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] result_map
);

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   map_q, map_d;

    logic                 expired;
    logic                 timer_clear_c;
    logic                 timer_en_c;
    logic                 match_c;

    // Counter only runs in SETTLE; cleared on expiry so each vector starts at 0
    assign timer_en_c    = (state_q == ST_SETTLE);
    assign timer_clear_c = abort || (state_q != ST_SETTLE) || expired;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_c),
        .enable  (timer_en_c),
        .expired (expired)
    );

    assign match_c = vec_match(GOLDEN, vec_q, dut_out);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        map_d   = map_q;

        if (abort) begin
            // Partial err_cnt/result_map are kept for debug
            state_d = ST_IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_SETTLE;
                        vec_d   = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        err_d   = '0;
                        map_d   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (expired) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    map_d[vec_q] = match_c;
                    err_d        = err_q + ERR_W'(!match_c);
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = ST_SETTLE;
                        vec_d   = vec_q + VEC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            map_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            map_q   <= map_d;
        end
    end

    // The applied vector and its index are the same register
    assign drv_a      = vec_q[2];
    assign drv_b      = vec_q[1];
    assign drv_c      = vec_q[0];
    assign vec_idx    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign result_map = map_q;

endmodule

// File: tb/tb_eq3_sweep_ctrl.sv
// Bench for eq3_sweep_ctrl: three builds (SETTLE=2, SETTLE=1, majority golden)
// driving behavioural gate models, with a scoreboard of expected sweep results.
module tb_eq3_sweep_ctrl;

    typedef struct {
        logic [3:0] err;
        logic [7:0] map;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start_r   [3];
    logic       abort_r   [3];
    logic [1:0] mode      [3];
    logic [7:0] gold      [3];
    logic       dut_out_w [3];
    logic       drv_a_w   [3];
    logic       drv_b_w   [3];
    logic       drv_c_w   [3];
    logic [2:0] vec_w     [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       pass_w    [3];
    logic [3:0] err_w     [3];
    logic [7:0] map_w     [3];

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    // mode 0: eq3 via p1/p2/or, 1: stuck-at-0, 2: inverted eq3, 3: majority
    function automatic logic gate(input logic [1:0] m, input logic [2:0] v);
        logic p1, p2;
        p1 = !v[2] && !v[1] && !v[0];
        p2 = v[2] && v[1] && v[0];
        case (m)
            2'd0:    return p1 || p2;
            2'd1:    return 1'b0;
            2'd2:    return !(p1 || p2);
            default: return (v[2] && v[1]) || (v[2] && v[0]) || (v[1] && v[0]);
        endcase
    endfunction

    assign dut_out_w[0] = gate(mode[0], {drv_a_w[0], drv_b_w[0], drv_c_w[0]});
    assign dut_out_w[1] = gate(mode[1], {drv_a_w[1], drv_b_w[1], drv_c_w[1]});
    assign dut_out_w[2] = gate(mode[2], {drv_a_w[2], drv_b_w[2], drv_c_w[2]});

    eq3_sweep_ctrl #(.SETTLE(2), .GOLDEN(8'h81)) u_dut (
        .clk(clk), .rst(rst), .start(start_r[0]), .abort(abort_r[0]),
        .dut_out(dut_out_w[0]), .drv_a(drv_a_w[0]), .drv_b(drv_b_w[0]),
        .drv_c(drv_c_w[0]), .vec_idx(vec_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
        .result_map(map_w[0])
    );

    eq3_sweep_ctrl #(.SETTLE(1), .GOLDEN(8'h81)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .abort(abort_r[1]),
        .dut_out(dut_out_w[1]), .drv_a(drv_a_w[1]), .drv_b(drv_b_w[1]),
        .drv_c(drv_c_w[1]), .vec_idx(vec_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
        .result_map(map_w[1])
    );

    eq3_sweep_ctrl #(.SETTLE(2), .GOLDEN(8'hE8)) u_dut_maj (
        .clk(clk), .rst(rst), .start(start_r[2]), .abort(abort_r[2]),
        .dut_out(dut_out_w[2]), .drv_a(drv_a_w[2]), .drv_b(drv_b_w[2]),
        .drv_c(drv_c_w[2]), .vec_idx(vec_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]),
        .result_map(map_w[2])
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int k);
        exp_t e;
        logic [7:0] g;
        g     = gold[k];
        e.err = 4'd0;
        e.map = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (gate(mode[k], 3'(i)) === g[i]) e.map[i] = 1'b1;
            else                               e.err = e.err + 4'd1;
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    function automatic logic all_zero(input int k);
        return drv_a_w[k] === 1'b0 && drv_b_w[k] === 1'b0 && drv_c_w[k] === 1'b0 &&
               vec_w[k] === 3'd0 && busy_w[k] === 1'b0 && done_w[k] === 1'b0 &&
               pass_w[k] === 1'b0 && err_w[k] === 4'd0 && map_w[k] === 8'd0;
    endfunction

    // Full sweep on instance k: checks start-edge clearing, drv sequence, latency, results
    task automatic do_sweep(input int k, input int s, input bit hold, input string tag);
        exp_t e;
        int   done_at;
        bit   drv_bad;
        int   lat;
        lat = 8 * (s + 1);
        sb.push_back(model(k));
        start_r[k] = 1'b1;
        tick();
        if (!hold) start_r[k] = 1'b0;
        n_tests++;
        if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0 || err_w[k] !== 4'd0 || map_w[k] !== 8'd0) begin
            n_fail++;
            $display("FAIL %s start_edge: busy=%b done=%b err=%0d map=%h, want busy=1 done=0 err=0 map=00",
                     tag, busy_w[k], done_w[k], err_w[k], map_w[k]);
        end
        drv_bad = 1'b0;
        done_at = -1;
        for (int n = 0; n < lat + 8; n++) begin
            if (n > 0) tick();
            if (done_w[k] === 1'b1) begin
                done_at    = n;
                start_r[k] = 1'b0;
                break;
            end
            if ({drv_a_w[k], drv_b_w[k], drv_c_w[k]} !== 3'(n / (s + 1)) ||
                vec_w[k] !== 3'(n / (s + 1)) || busy_w[k] !== 1'b1)
                drv_bad = 1'b1;
        end
        start_r[k] = 1'b0;
        n_tests++;
        if (done_at != lat) begin
            n_fail++;
            $display("FAIL %s latency: done at cycle %0d, want %0d", tag, done_at, lat);
        end
        n_tests++;
        if (drv_bad) begin
            n_fail++;
            $display("FAIL %s drv_seq: vector sequence/hold or busy wrong, want each vector held %0d cycles", tag, s + 1);
        end
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, want one entry", tag);
        end else begin
            e = sb.pop_front();
            if (err_w[k] !== e.err || map_w[k] !== e.map || pass_w[k] !== e.pass ||
                busy_w[k] !== 1'b0 || vec_w[k] !== 3'd7) begin
                n_fail++;
                $display("FAIL %s result: err=%0d map=%h pass=%b busy=%b vec=%0d, want err=%0d map=%h pass=%b busy=0 vec=7",
                         tag, err_w[k], map_w[k], pass_w[k], busy_w[k], vec_w[k], e.err, e.map, e.pass);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (!all_zero(k)) begin
                n_fail++;
                $display("FAIL reset_values inst%0d: busy=%b done=%b err=%0d map=%h vec=%0d, want all 0",
                         k, busy_w[k], done_w[k], err_w[k], map_w[k], vec_w[k]);
            end
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_golden_sweep();
        mode[0] = 2'd0;
        do_sweep(0, 2, 1'b0, "eq3_gate");
    endtask

    task automatic test_faulty_gate();
        mode[0] = 2'd1;
        do_sweep(0, 2, 1'b0, "stuck_at_0");
        mode[0] = 2'd2;
        do_sweep(0, 2, 1'b0, "inverted_gate");
        mode[0] = 2'd0;
    endtask

    task automatic test_abort();
        exp_t e;
        mode[0]    = 2'd0;
        e          = model(0);
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        for (int n = 0; n < 9; n++) tick();
        n_tests++;
        if (vec_w[0] !== 3'd3 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: vec=%0d busy=%b, want vec=3 busy=1", vec_w[0], busy_w[0]);
        end
        abort_r[0] = 1'b1;
        tick();
        abort_r[0] = 1'b0;
        n_tests++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || pass_w[0] !== 1'b0 ||
            {drv_a_w[0], drv_b_w[0], drv_c_w[0]} !== 3'b000 || vec_w[0] !== 3'd0 ||
            map_w[0] !== (e.map & 8'h07) || err_w[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b pass=%b vec=%0d map=%h err=%0d, want 0/0/0/0 map=%h err=0",
                     busy_w[0], done_w[0], pass_w[0], vec_w[0], map_w[0], err_w[0], e.map & 8'h07);
        end
        tick();
        tick();
        n_tests++;
        if (busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: busy=%b, want 0", busy_w[0]);
        end
        do_sweep(0, 2, 1'b0, "after_abort");
        // abort wins over start when both are high in DONE
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        n_tests++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || vec_w[0] !== 3'd0 || pass_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_priority: busy=%b done=%b vec=%0d pass=%b, want 0/0/0/0",
                     busy_w[0], done_w[0], vec_w[0], pass_w[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mode[0] = 2'd0;
        do_sweep(0, 2, 1'b1, "start_held");
        mode[0] = 2'd1;
        do_sweep(0, 2, 1'b0, "restart_a");
        mode[0] = 2'd0;
        do_sweep(0, 2, 1'b0, "restart_from_done");
    endtask

    task automatic test_async_reset();
        mode[0]    = 2'd0;
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (!all_zero(0)) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b err=%0d map=%h vec=%0d, want all 0 before next edge",
                     busy_w[0], done_w[0], err_w[0], map_w[0], vec_w[0]);
        end
        #1;
        rst = 1'b0;
        tick();
        n_tests++;
        if (busy_w[0] !== 1'b0 || vec_w[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b vec=%0d, want 0/0", busy_w[0], vec_w[0]);
        end
        mode[1] = 2'd0;
        do_sweep(1, 1, 1'b0, "settle_1");
    endtask

    task automatic test_majority_golden();
        mode[2] = 2'd3;
        do_sweep(2, 2, 1'b0, "maj_gate");
        mode[2] = 2'd0;
        do_sweep(2, 2, 1'b0, "maj_golden_eq3_gate");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        gold[0] = 8'h81;
        gold[1] = 8'h81;
        gold[2] = 8'hE8;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0;
            abort_r[k] = 1'b0;
            mode[k]    = 2'd0;
        end
        test_reset();
        test_golden_sweep();
        test_faulty_gate();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_majority_golden();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
